tile_accum_writeback: RTL
=========================

Name: tile_accum_writeback

Overview:
- Consumer end of the tiled-matmul sequencer: takes partial-sum tiles tagged with the (i, j, k) tile indices, accumulates them over k, and writes each finished C tile to result memory row by row.
- Sits between the systolic array output and the C-matrix memory write port.
- Raises done after the last (i, j) tile has drained.

Parameters:
- ROW_M, 16, square matrix dimension (elements); multiple of TILE.
- TILE, 4, tile edge (VLEN/SEW); rows per tile and elements per row beat.
- DW, 32, partial-sum / result element width (two's complement).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  a partial-sum row beat is present.
- in_ready  out  1  block accepts the beat this cycle.
- in_i  in  $clog2(ROW_M)  tile row index of the beat.
- in_j  in  $clog2(ROW_M)  tile column index of the beat.
- in_k  in  $clog2(ROW_M)  reduction index of the beat.
- in_data  in  TILE*DW  one tile row of partial sums; element c at bits [c*DW +: DW].
- wr_valid  out  1  write beat present.
- wr_ready  in  1  memory accepts the write beat.
- wr_addr  out  $clog2(ROW_M*ROW_M)  element address of the row start = (i+r)*ROW_M + j.
- wr_data  out  TILE*DW  accumulated tile row, same packing as in_data.
- err  out  1  sticky protocol error.
- done  out  1  sticky, all tiles written.

Behaviour:
- Reset values: in_ready=0, wr_valid=0, wr_addr=0, wr_data=0, err=0, done=0; state=ACCUM; row_cnt=0; buffer contents don't-care. in_ready goes to 1 in the first cycle after reset deasserts.
- Reset mid-operation aborts everything with no partial writes issued afterwards.
- States:
  - ACCUM: in_ready=1. A beat is accepted when in_valid && in_ready.
  - DRAIN: in_ready=0. Emit TILE write beats.
  - DONE: in_ready=0, wr_valid=0, done=1.
- Beats per k-step: TILE beats, one per tile row, with row_cnt 0..TILE-1 selecting buffer row r.
- Accumulation on an accepted beat:
  - in_k==0: buf[r][c] <= in_data element c (overwrite).
  - otherwise: buf[r][c] <= buf[r][c] + element c, wrapping modulo 2^DW.
- Tile latch: on the first beat with in_k==0, latch tile_i=in_i and tile_j=in_j. Expected next k = in_k+TILE after row_cnt wraps.
- err is set (never cleared except by reset) when any of these occurs:
  - in_k != 0 and (in_i, in_j) != latched tile; or
  - in_k != the expected k; or
  - in_i or in_j is not a multiple of TILE.
  - The beat is still accumulated. Sequencing is unaffected.
- ACCUM -> DRAIN: on acceptance of beat row_cnt==TILE-1 with in_k==ROW_M-TILE. row_cnt resets to 0.
- DRAIN:
  - wr_valid=1. wr_data and wr_addr are registered from buf[r] with r=row_cnt, tile_i, tile_j.
  - Values are stable while wr_valid && !wr_ready (no change under backpressure).
  - Each wr_valid && wr_ready advances r.
  - The first write beat appears the cycle after the last input beat is accepted (latency 1). With wr_ready held at 1, there are TILE consecutive write cycles.
- DRAIN exit, after the handshake on r==TILE-1:
  - If tile_i==ROW_M-TILE and tile_j==ROW_M-TILE, go to DONE.
  - Otherwise go to ACCUM; in_ready=1 the next cycle.
- Beats presented while in_ready=0 are held by the producer (not dropped, not counted).
- DONE is terminal until reset; in_valid is ignored there.
- Tile order is whatever the producer sends. Only the last-tile test decides DONE.

Test Plan:
- ROW_M=8, TILE=4, DW=32, wr_ready=1, all in_data elements=1, four tiles (i,j in {0,4}) each k=0,4 -> 16 write beats, every element=2. Addresses per tile (i,j): (i+r)*8+j, e.g. tile (4,0) -> 32,40,48,56. done=1 one cycle after the last write handshake. err=0.
- Overwrite check: first tile with stale buffer from a prior tile, k=0 data=5, k=4 data=7 -> wr_data elements=12 (no carry-over of old contents).
- Backpressure: wr_ready low 3 cycles during drain row 1 -> wr_data/wr_addr stable, no beat skipped or duplicated, in_ready=0 throughout DRAIN.
- Wrap: k=0 element 0xFFFFFFFF, k=4 element 2 -> written value 0x00000001. err=0.
- Protocol error: tile (0,0) k=0, then beat with in_i=4 k=4 -> err=1 and stays 1; block still drains 4 beats at addresses 0,8,16,24.
- Reset asserted during DRAIN after 2 of 4 writes -> next cycle wr_valid=0, done=0, err=0; new tile sequence completes normally.

Source files
------------

// File: rtl/tile_accum_writeback.sv
// Accumulates k-tagged partial-sum tile rows into a TILE x TILE buffer and
// writes each finished C tile to result memory one row per beat.
module tile_accum_writeback #(
  parameter int ROW_M = 16,
  parameter int TILE  = 4,
  parameter int DW    = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [$clog2(ROW_M)-1:0]         in_i,
  input  logic [$clog2(ROW_M)-1:0]         in_j,
  input  logic [$clog2(ROW_M)-1:0]         in_k,
  input  logic [TILE*DW-1:0]               in_data,
  output logic                             wr_valid,
  input  logic                             wr_ready,
  output logic [$clog2(ROW_M*ROW_M)-1:0]   wr_addr,
  output logic [TILE*DW-1:0]               wr_data,
  output logic                             err,
  output logic                             done
);

  localparam int IW = $clog2(ROW_M);
  localparam int AW = $clog2(ROW_M*ROW_M);
  localparam int RW = (TILE > 1) ? $clog2(TILE) : 1;
  localparam logic [RW-1:0] LAST_R = RW'(TILE-1);
  localparam logic [IW-1:0] LAST_K = IW'(ROW_M-TILE);

  typedef enum logic [1:0] {ACCUM, DRAIN, DONE} state_t;

  state_t             state;
  logic [RW-1:0]      row_cnt;
  logic [RW-1:0]      next_r;
  logic [IW-1:0]      tile_i;
  logic [IW-1:0]      tile_j;
  logic [IW-1:0]      exp_k;
  logic [IW-1:0]      lat_i;
  logic [IW-1:0]      lat_j;
  logic [TILE*DW-1:0] acc_buf [TILE];
  logic [TILE*DW-1:0] acc_row;
  logic               accept;
  logic               last_row;
  logic               bad_beat;

  function automatic logic [AW-1:0] row_addr(input logic [IW-1:0] ti,
                                             input logic [IW-1:0] tj,
                                             input logic [RW-1:0] r);
    return AW'((int'(ti) + int'(r)) * ROW_M + int'(tj));
  endfunction

  always_comb begin
    accept   = in_valid && in_ready && (state == ACCUM);
    last_row = (row_cnt == LAST_R);
    next_r   = row_cnt + RW'(1);
    acc_row  = '0;
    for (int unsigned c = 0; c < TILE; c++) begin
      acc_row[c*DW +: DW] = (in_k == '0) ? in_data[c*DW +: DW]
                                         : acc_buf[row_cnt][c*DW +: DW] + in_data[c*DW +: DW];
    end
    // Tile indices as they will be after this beat (matters when TILE==1).
    lat_i    = (row_cnt == '0 && in_k == '0) ? in_i : tile_i;
    lat_j    = (row_cnt == '0 && in_k == '0) ? in_j : tile_j;
    bad_beat = (in_k != exp_k)
            || ((in_k != '0) && ((in_i != tile_i) || (in_j != tile_j)))
            || ((int'(in_i) % TILE) != 0)
            || ((int'(in_j) % TILE) != 0);
  end

  always_ff @(posedge clk) begin
    if (accept && !reset) acc_buf[row_cnt] <= acc_row;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ACCUM;
      in_ready <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      err      <= 1'b0;
      done     <= 1'b0;
      row_cnt  <= '0;
      exp_k    <= '0;
      tile_i   <= '0;
      tile_j   <= '0;
    end else begin
      case (state)
        ACCUM: begin
          in_ready <= 1'b1;
          if (accept) begin
            if (bad_beat) err <= 1'b1;
            tile_i <= lat_i;
            tile_j <= lat_j;
            if (last_row) begin
              row_cnt <= '0;
              if (in_k == LAST_K) begin
                state    <= DRAIN;
                in_ready <= 1'b0;
                exp_k    <= '0;
                wr_valid <= 1'b1;
                wr_data  <= (TILE == 1) ? acc_row : acc_buf[0];
                wr_addr  <= row_addr(lat_i, lat_j, '0);
              end else begin
                exp_k <= in_k + IW'(TILE);
              end
            end else begin
              row_cnt <= next_r;
            end
          end
        end
        DRAIN: begin
          if (wr_ready) begin
            if (last_row) begin
              wr_valid <= 1'b0;
              row_cnt  <= '0;
              if (tile_i == LAST_K && tile_j == LAST_K) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state    <= ACCUM;
                in_ready <= 1'b1;
              end
            end else begin
              row_cnt <= next_r;
              wr_data <= acc_buf[next_r];
              wr_addr <= row_addr(tile_i, tile_j, next_r);
            end
          end
        end
        DONE: begin
          in_ready <= 1'b0;
          wr_valid <= 1'b0;
          done     <= 1'b1;
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
